// File: rtl/reg_write_demux16.sv
// rtl/reg_write_demux16.sv - 16-entry write-decoded register bank with two combinational read ports
module reg_write_demux16 #(
    parameter int WIDTH    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             WE,
    input  logic [3:0]       WAddr,
    input  logic [WIDTH-1:0] WData,
    input  logic [3:0]       RAddrA,
    input  logic [3:0]       RAddrB,
    output logic [WIDTH-1:0] RDataA,
    output logic [WIDTH-1:0] RDataB,
    output logic [15:0]      Written
);

    logic [WIDTH-1:0] regs [16];
    logic [15:0]      wr_dec;

    // One-hot write strobe; entry 0 never strobes when it is the hardwired zero.
    always_comb begin
        wr_dec = '0;
        if (WE && !(ZERO_REG && (WAddr == 4'd0))) begin
            wr_dec[WAddr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int k = 0; k < 16; k++) begin
                regs[k] <= '0;
            end
            Written <= '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (wr_dec[k]) begin
                    regs[k] <= WData;
                end
            end
            Written <= Written | wr_dec;
        end
    end

    // No write bypass: reads always show the value held before the edge.
    assign RDataA = regs[RAddrA];
    assign RDataB = regs[RAddrB];

endmodule

// File: tb/tb_reg_write_demux16.sv
// tb/tb_reg_write_demux16.sv - directed self-checking bench for reg_write_demux16
module tb_reg_write_demux16;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        WE;
    logic [3:0]  WAddr;
    logic [15:0] WData;
    logic [3:0]  RAddrA;
    logic [3:0]  RAddrB;
    logic [15:0] rda_z, rdb_z, wr_z;
    logic [15:0] rda_n, rdb_n, wr_n;

    int checks = 0;
    int errors = 0;

    reg_write_demux16 #(.WIDTH(16), .ZERO_REG(1'b1)) u_zero (
        .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .WData(WData),
        .RAddrA(RAddrA), .RAddrB(RAddrB),
        .RDataA(rda_z), .RDataB(rdb_z), .Written(wr_z)
    );

    reg_write_demux16 #(.WIDTH(16), .ZERO_REG(1'b0)) u_plain (
        .CLK(CLK), .Reset(Reset), .WE(WE), .WAddr(WAddr), .WData(WData),
        .RAddrA(RAddrA), .RAddrB(RAddrB),
        .RDataA(rda_n), .RDataB(rdb_n), .Written(wr_n)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; WE = 1'b0; WAddr = 4'd0; WData = 16'h0000;
        RAddrA = 4'd0; RAddrB = 4'd0;
        tick();
        Reset = 1'b0;

        // Reset sweep
        for (int k = 0; k < 16; k++) begin
            RAddrA = 4'(k);
            #1;
            chk($sformatf("reset_rda_z[%0d]", k), rda_z, 16'h0000);
            chk($sformatf("reset_rda_n[%0d]", k), rda_n, 16'h0000);
        end
        chk("reset_written_z", wr_z, 16'h0000);
        chk("reset_written_n", wr_n, 16'h0000);

        // Fill entries 1..15
        WE = 1'b1;
        for (int k = 1; k < 16; k++) begin
            WAddr = 4'(k);
            WData = 16'h1000 + 16'(k);
            tick();
        end
        WE = 1'b0;
        for (int k = 0; k < 16; k++) begin
            RAddrA = 4'(k);
            RAddrB = 4'(15 - k);
            #1;
            chk($sformatf("fill_rda[%0d]", k), rda_z, (k == 0) ? 16'h0000 : 16'h1000 + 16'(k));
            chk($sformatf("fill_rdb[%0d]", k), rdb_z, (k == 15) ? 16'h0000 : 16'h1000 + 16'(15 - k));
        end
        chk("fill_written_z", wr_z, 16'hFFFE);
        chk("fill_written_n", wr_n, 16'hFFFE);

        // Zero register
        WE = 1'b1; WAddr = 4'd0; WData = 16'hBEEF;
        tick();
        WE = 1'b0; RAddrA = 4'd0; RAddrB = 4'd0;
        #1;
        chk("zero_rda_z", rda_z, 16'h0000);
        chk("zero_rdb_z", rdb_z, 16'h0000);
        chk("zero_written_z", wr_z, 16'hFFFE);
        chk("zero_rda_n", rda_n, 16'hBEEF);
        chk("zero_written_n", wr_n, 16'hFFFF);

        // Write-enable gating
        WE = 1'b0; WAddr = 4'd4; WData = 16'hFFFF;
        tick(); tick(); tick();
        RAddrA = 4'd4;
        #1;
        chk("gate_rda", rda_z, 16'h1004);
        chk("gate_written_z", wr_z, 16'hFFFE);
        chk("gate_written_n", wr_n, 16'hFFFF);

        // Read-during-write, no bypass
        WE = 1'b1; WAddr = 4'd5; WData = 16'h0005;
        tick();
        WData = 16'hA5A5; RAddrA = 4'd5; RAddrB = 4'd5;
        #1;
        chk("rdw_before_a", rda_z, 16'h0005);
        chk("rdw_before_b", rdb_z, 16'h0005);
        tick();
        WE = 1'b0;
        #1;
        chk("rdw_after_a", rda_z, 16'hA5A5);
        chk("rdw_after_b", rdb_z, 16'hA5A5);

        // Reset priority over a concurrent write
        Reset = 1'b1; WE = 1'b1; WAddr = 4'd3; WData = 16'h1234;
        tick();
        Reset = 1'b0; WE = 1'b0;
        for (int k = 0; k < 16; k++) begin
            RAddrA = 4'(k);
            RAddrB = 4'(k);
            #1;
            chk($sformatf("rstprio_rda_z[%0d]", k), rda_z, 16'h0000);
            chk($sformatf("rstprio_rdb_n[%0d]", k), rdb_n, 16'h0000);
        end
        chk("rstprio_written_z", wr_z, 16'h0000);
        chk("rstprio_written_n", wr_n, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_demux16.md
Name: reg_write_demux16

Overview:
- 16-entry x 16-bit register bank. Writes are routed by a 4-bit select, the demux/decode direction of the 16:1 result mux.
- Sits at the processor write-back stage. Holds architectural registers and feeds two combinational read ports to the ALU operand muxes.
- Tracks which entries have been written since reset.

Parameters:
- WIDTH, 16, data width of each register and of all data ports.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and ignores writes; when 0 entry 0 is an ordinary register.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- WE  input  1  write enable, sampled at the CLK rising edge.
- WAddr  input  4  write select; decodes to one of 16 entries.
- WData  input  WIDTH  write data.
- RAddrA  input  4  read select, port A.
- RAddrB  input  4  read select, port B.
- RDataA  output  WIDTH  contents of entry RAddrA.
- RDataB  output  WIDTH  contents of entry RAddrB.
- Written  output  16  bit k = 1 when entry k has accepted a write since the last reset.

Behaviour:
- Clocking: one clock domain, CLK. Reset is synchronous and active-high. All state changes on the CLK rising edge only.
- Reset:
  - Reset=1 at an edge clears all 16 entries to 0 and Written to 16'h0000.
  - Reset has priority over WE in the same cycle.
  - Reset asserted mid-sequence discards any write presented in that cycle.
- Write decode:
  - At an edge with Reset=0 and WE=1, entry WAddr takes WData.
  - Exactly one entry is updated; the other 15 hold.
  - Written[WAddr] sets to 1. Written bits never clear except by Reset.
- WE=0: no entry or Written bit changes, whatever WAddr and WData are.
- Zero register (ZERO_REG=1):
  - A write to WAddr=0 is discarded; entry 0 stays 0.
  - Written[0] stays 0.
  - A read of address 0 always returns 0.
- Reads:
  - Purely combinational from the stored entries. Zero-cycle latency after the select changes.
  - RDataA/RDataB equal the registered value of the selected entry.
- Read-during-write:
  - No bypass. In the cycle WE=1 and RAddrA (or RAddrB) == WAddr, the read port shows the old value.
  - The new value appears after the edge.
- Both read ports may select the same entry; both return the same value.
- Width rule: WData is stored unmodified, WIDTH bits, no sign/zero extension.
- Outputs after reset release: RDataA = RDataB = 0 for all addresses; Written = 0.

Test Plan:
- Reset then sweep: assert Reset 1 cycle; set RAddrA through 0..15 -> RDataA=0 for every address, Written=16'h0000.
- Fill and read back: WE=1, write WData=16'h1000+k to WAddr=k for k=1..15 over 15 cycles; then RAddrA=k, RAddrB=15-k -> RDataA=16'h1000+k, RDataB=16'h1000+(15-k) (0 when 15-k=0); Written=16'hFFFE.
- Zero register: WE=1, WAddr=0, WData=16'hBEEF -> after the edge RDataA(RAddrA=0)=0, Written[0]=0; with ZERO_REG=0 -> RDataA=16'hBEEF, Written[0]=1.
- Write-enable gating: WE=0, WAddr=4, WData=16'hFFFF for 3 cycles -> entry 4 and Written unchanged.
- Read-during-write: entry 5=16'h0005; WE=1, WAddr=5, WData=16'hA5A5, RAddrA=5 -> RDataA=16'h0005 before the edge, 16'hA5A5 after.
- Reset priority mid-operation: entries loaded; Reset=1 and WE=1, WAddr=3, WData=16'h1234 in the same cycle -> entry 3=0, all entries 0, Written=16'h0000.
